logic_unit_pipe: RTL and testbench

//  Parametrised, pipelined logic unit for the CPU execute stage. Performs AND/OR/XOR/NOR/XNOR/NOT
//  on WIDTH-bit operands with valid/ready flow control. Produces zero/parity/error flags and keeps
//  an accumulator that any op may use as operand1. Arithmetic codes are handled by the adder block.

---
 rtl/logic_unit_pipe.sv | 158 +++++++++++++++
 tb/tb_logic_unit_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready flow control,
// result flags and an optional chaining accumulator.
module logic_unit_pipe #(
    parameter int WIDTH  = 16,
    parameter bit ACC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       control,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             use_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic             err,
    output logic [WIDTH-1:0] acc
);

    typedef enum logic [2:0] {
        OP_RSV0 = 3'b000,
        OP_RSV1 = 3'b001,
        OP_NOT  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_NOR  = 3'b110,
        OP_XNOR = 3'b111
    } op_e;

    function automatic logic calc_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    function automatic logic calc_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    // Stage 1 holding registers
    logic             r_s1_valid;
    logic [2:0]       r_s1_ctrl;
    logic [WIDTH-1:0] r_s1_op1;
    logic [WIDTH-1:0] r_s1_op2;
    logic             r_s1_use_acc;

    // Stage 2 (output) registers
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_parity;
    logic             r_err;

    logic [WIDTH-1:0] r_acc;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_move;
    logic [WIDTH-1:0] w_op1;
    logic [WIDTH-1:0] w_res;
    logic             w_err;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_move   = r_s1_valid && w_s2_adv;

    // Operand select and bitwise operation for the beat leaving stage 1
    always_comb begin
        w_op1 = r_s1_op1;
        w_res = {WIDTH{1'b0}};
        w_err = 1'b0;
        if (ACC_EN && r_s1_use_acc) begin
            w_op1 = r_acc;
        end else begin
            w_op1 = r_s1_op1;
        end
        case (r_s1_ctrl)
            OP_NOT:  w_res = ~w_op1;
            OP_AND:  w_res = w_op1 & r_s1_op2;
            OP_OR:   w_res = w_op1 | r_s1_op2;
            OP_XOR:  w_res = w_op1 ^ r_s1_op2;
            OP_NOR:  w_res = ~(w_op1 | r_s1_op2);
            OP_XNOR: w_res = ~(w_op1 ^ r_s1_op2);
            OP_RSV0, OP_RSV1: begin
                w_res = {WIDTH{1'b0}};
                w_err = 1'b1;
            end
            default: begin
                w_res = {WIDTH{1'b0}};
                w_err = 1'b1;
            end
        endcase
    end

    // Stage 1 capture: loads whenever the stage is free or draining
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_ctrl    <= 3'b000;
            r_s1_op1     <= {WIDTH{1'b0}};
            r_s1_op2     <= {WIDTH{1'b0}};
            r_s1_use_acc <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_ctrl    <= control;
                r_s1_op1     <= operand1;
                r_s1_op2     <= operand2;
                r_s1_use_acc <= use_acc;
            end
        end
    end

    // Stage 2 capture: result and flags only change on a stage move, so they hold under stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_result   <= {WIDTH{1'b0}};
            r_zero     <= 1'b0;
            r_parity   <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_res;
                r_zero   <= calc_zero(w_res);
                r_parity <= calc_parity(w_res);
                r_err    <= w_err;
            end
        end
    end

    // Accumulator: clear beats a same-cycle update; unsupported codes never write it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= {WIDTH{1'b0}};
        end else if (!ACC_EN) begin
            r_acc <= {WIDTH{1'b0}};
        end else if (acc_clr) begin
            r_acc <= {WIDTH{1'b0}};
        end else if (w_move && !w_err) begin
            r_acc <= w_res;
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign parity    = r_parity;
    assign err       = r_err;
    assign acc       = r_acc;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe: a 16-bit accumulator
// instance and an 8-bit instance built without the accumulator.
module tb_logic_unit_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, use_acc, acc_clr, out_valid, out_ready;
    logic [2:0]  control;
    logic [15:0] operand1, operand2, result, acc;
    logic        zero, parity, err;

    logic        in_valid_b, in_ready_b, use_acc_b, acc_clr_b, out_valid_b, out_ready_b;
    logic [2:0]  control_b;
    logic [7:0]  operand1_b, operand2_b, result_b, acc_b;
    logic        zero_b, parity_b, err_b;

    logic_unit_pipe #(.WIDTH(16), .ACC_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .control(control), .operand1(operand1), .operand2(operand2),
        .use_acc(use_acc), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .parity(parity),
        .err(err), .acc(acc)
    );

    logic_unit_pipe #(.WIDTH(8), .ACC_EN(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .control(control_b), .operand1(operand1_b), .operand2(operand2_b),
        .use_acc(use_acc_b), .acc_clr(acc_clr_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .result(result_b), .zero(zero_b), .parity(parity_b),
        .err(err_b), .acc(acc_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output beats completed by a handshake, packed as {err, parity, zero, result}
    logic [18:0] q[$];
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) q.push_back({err, parity, zero, result});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                        input logic ua);
        in_valid = 1'b1;
        control  = c;
        operand1 = a;
        operand2 = b;
        use_acc  = ua;
    endtask

    logic [2:0]  t3c[4] = '{3'b011, 3'b100, 3'b101, 3'b111};
    logic [15:0] t3a[4] = '{16'h1234, 16'h0F00, 16'hFFFF, 16'h00FF};
    logic [15:0] t3b[4] = '{16'hFFFF, 16'h00F0, 16'h0001, 16'h0F0F};
    logic [15:0] t3e[4] = '{16'h1234, 16'h0FF0, 16'hFFFE, 16'hF00F};

    initial begin
        int  idx;
        bit  acc_now;
        reset = 1'b1;
        in_valid = 1'b0; control = 3'b000; operand1 = 16'h0; operand2 = 16'h0;
        use_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        in_valid_b = 1'b0; control_b = 3'b000; operand1_b = 8'h0; operand2_b = 8'h0;
        use_acc_b = 1'b0; acc_clr_b = 1'b0; out_ready_b = 1'b1;

        // Reset state
        repeat (2) tick();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_zero", 32'(zero), 32'h0);
        check("rst_parity", 32'(parity), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_acc", 32'(acc), 32'h0);
        reset = 1'b0;
        tick();

        // Two back-to-back ops, two-cycle latency
        beat(3'b011, 16'hF0F0, 16'hFF00, 1'b0);
        tick();
        beat(3'b101, 16'hAAAA, 16'h5555, 1'b0);
        tick();
        check("and_valid", 32'(out_valid), 32'h1);
        check("and_result", 32'(result), 32'h0000F000);
        check("and_zero", 32'(zero), 32'h0);
        check("and_parity", 32'(parity), 32'h0);
        in_valid = 1'b0;
        tick();
        check("xor_valid", 32'(out_valid), 32'h1);
        check("xor_result", 32'(result), 32'h0000FFFF);
        check("xor_parity", 32'(parity), 32'h0);
        tick();
        check("drain_valid", 32'(out_valid), 32'h0);

        // Backpressure: five stalled cycles, four beats offered
        q.delete();
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            out_ready = (c >= 5);
            if (idx < 4) beat(t3c[idx], t3a[idx], t3b[idx], 1'b0);
            else in_valid = 1'b0;
            @(negedge clk);
            if (c >= 2 && c < 5) begin
                check("bp_in_ready", 32'(in_ready), 32'h0);
                check("bp_hold_result", 32'(result), 32'h00001234);
                check("bp_hold_valid", 32'(out_valid), 32'h1);
            end
            acc_now = in_valid && in_ready;
            tick();
            if (acc_now) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd4);
        check("bp_count", 32'(q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < q.size()) check("bp_order", 32'(q[i][15:0]), 32'(t3e[i]));
        end

        // Accumulator chaining with no bubble
        q.delete();
        out_ready = 1'b1;
        beat(3'b100, 16'h0000, 16'h00FF, 1'b0);
        tick();
        beat(3'b101, 16'hDEAD, 16'h0F0F, 1'b1);
        tick();
        beat(3'b110, 16'hBEEF, 16'h0000, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("acc_count", 32'(q.size()), 32'd3);
        if (q.size() == 3) begin
            check("acc_or", 32'(q[0][15:0]), 32'h000000FF);
            check("acc_xor", 32'(q[1][15:0]), 32'h00000FF0);
            check("acc_nor", 32'(q[2][15:0]), 32'h0000F00F);
        end
        check("acc_final", 32'(acc), 32'h0000F00F);

        // Unsupported code
        q.delete();
        beat(3'b000, 16'h1234, 16'h1234, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("unsup_count", 32'(q.size()), 32'd1);
        if (q.size() == 1) check("unsup_flags", 32'(q[0]), 32'h00050000);
        check("unsup_acc_kept", 32'(acc), 32'h0000F00F);

        // Clear in the same cycle as a use_acc move
        beat(3'b011, 16'h0000, 16'hFFFF, 1'b1);
        tick();
        in_valid = 1'b0;
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("clr_acc", 32'(acc), 32'h0);
        check("clr_valid", 32'(out_valid), 32'h1);
        check("clr_result_old_acc", 32'(result), 32'h0000F00F);
        check("clr_err", 32'(err), 32'h0);
        tick();

        // Reset with two beats in flight
        beat(3'b100, 16'h1111, 16'h0000, 1'b0);
        tick();
        beat(3'b100, 16'h2222, 16'h0000, 1'b0);
        tick();
        in_valid = 1'b0;
        check("pre_rst_acc", 32'(acc), 32'h00001111);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_acc", 32'(acc), 32'h0);
        check("mid_rst_result", 32'(result), 32'h0);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) tick();
        check("post_rst_outputs", 32'(q.size()), 32'd0);
        check("post_rst_valid", 32'(out_valid), 32'h0);

        // Narrow instance without accumulator: use_acc is ignored
        in_valid_b = 1'b1; control_b = 3'b010; operand1_b = 8'hA5; operand2_b = 8'h00;
        use_acc_b = 1'b1;
        tick();
        control_b = 3'b011; operand1_b = 8'h3C; operand2_b = 8'h0F;
        tick();
        check("w8_not_valid", 32'(out_valid_b), 32'h1);
        check("w8_not_result", 32'(result_b), 32'h0000005A);
        check("w8_not_parity", 32'(parity_b), 32'h0);
        check("w8_acc", 32'(acc_b), 32'h0);
        in_valid_b = 1'b0;
        tick();
        check("w8_and_result", 32'(result_b), 32'h0000000C);
        check("w8_acc_after", 32'(acc_b), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
